// File: rtl/uart_loader_pkg.sv
// Shared constants for the UART program loader: loader FSM encoding, default frame marker
// and small datapath helpers.
package uart_loader_pkg;

    localparam int STATE_W = 4;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_LEN_LO    = 4'd1;
    localparam logic [3:0] ST_LEN_HI    = 4'd2;
    localparam logic [3:0] ST_WAIT_DATA = 4'd3;
    localparam logic [3:0] ST_WR_SETUP  = 4'd4;
    localparam logic [3:0] ST_WR_PULSE  = 4'd5;
    localparam logic [3:0] ST_WR_HOLD   = 4'd6;
    localparam logic [3:0] ST_CHECK     = 4'd7;
    localparam logic [3:0] ST_DONE      = 4'd8;
    localparam logic [3:0] ST_ERR       = 4'd9;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Running image checksum: plain 8-bit sum, a good frame makes sum + CHK wrap to zero.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    function automatic logic is_busy_state(input logic [3:0] st);
        return !((st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERR));
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with input synchronizer, mid-bit sampling and a one-byte holding
// register; rx_valid stays high until the consumer acknowledges the held byte.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic [1:0]       rx_state_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic [7:0]       hold_data_r;
    logic             hold_full_r;
    logic             frame_err_r;
    logic             overrun_r;
    logic             stop_tick_s;
    logic             byte_done_s;
    logic             frame_bad_s;

    // Two-flop synchronizer, reset to the idle (high) line level
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Stop-bit sample outcome
    always_comb begin
        stop_tick_s = (rx_state_r == RX_STOP) && (bit_cnt_r == FULL_BIT);
        byte_done_s = stop_tick_s && rx_sync_r;
        frame_bad_s = stop_tick_s && !rx_sync_r;
    end

    // Bit timing: start re-check at half-bit, then one sample per bit period at mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            bit_cnt_r  <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    bit_cnt_r <= {CNT_W{1'b0}};
                    if (!rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_cnt_r == HALF_BIT) begin
                        bit_cnt_r  <= {CNT_W{1'b0}};
                        bit_idx_r  <= 3'd0;
                        // A high line here was only a glitch
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_cnt_r == FULL_BIT) begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_cnt_r == FULL_BIT) begin
                        bit_cnt_r  <= {CNT_W{1'b0}};
                        rx_state_r <= RX_IDLE;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    // Holding register and one-cycle error strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_r <= 1'b0;
            hold_data_r <= 8'h00;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= frame_bad_s;
            overrun_r   <= byte_done_s && hold_full_r && !rx_ack;
            if (byte_done_s) begin
                hold_full_r <= 1'b1;
                hold_data_r <= shift_r;
            end else if (rx_ack) begin
                hold_full_r <= 1'b0;
            end
        end
    end

    assign rx_data   = hold_data_r;
    assign rx_valid  = hold_full_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: rtl/uart_program_loader.sv
// UART boot loader: parses SYNC/LEN/payload/CHK frames, halts the core, writes the payload
// into instruction memory and releases the core with a one-cycle reset on a good checksum.
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter int         CLK_FREQ     = 100_000_000,
    parameter int         BAUD         = 115_200,
    parameter int         IMEM_BYTES   = 1024,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          uart_rx,
    output logic                          hlt,
    output logic                          pgm_mode,
    output logic [$clog2(IMEM_BYTES)-1:0] pgm_addr,
    output logic [7:0]                    pgm_data,
    output logic                          inst_mem_we,
    output logic                          cpu_rst,
    output logic                          busy,
    output logic                          load_done,
    output logic                          load_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int ADDR_W       = $clog2(IMEM_BYTES);
    localparam int REM_W        = ADDR_W + 1;

    logic [7:0]              rx_data_s;
    logic                    rx_valid_s;
    logic                    frame_err_s;
    logic                    overrun_s;
    logic                    rx_ack_s;
    logic [STATE_W-1:0]      state_r;
    logic [STATE_W-1:0]      state_nxt_s;
    logic [7:0]              len_lo_r;
    logic [15:0]             len_s;
    logic [REM_W-1:0]        remaining_r;
    logic [7:0]              sum_r;
    logic [TIMEOUT_BITS-1:0] tmo_cnt_r;
    logic                    timeout_s;
    logic                    err_s;
    logic                    sync_hit_s;
    logic                    hlt_r;
    logic [ADDR_W-1:0]       pgm_addr_r;
    logic [7:0]              pgm_data_r;
    logic                    we_r;
    logic                    cpu_rst_r;
    logic                    busy_r;
    logic                    load_done_r;
    logic                    load_err_r;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .rx       (uart_rx),
        .rx_ack   (rx_ack_s),
        .rx_data  (rx_data_s),
        .rx_valid (rx_valid_s),
        .frame_err(frame_err_s),
        .overrun  (overrun_s)
    );

    // Frame decode, error detection and byte acknowledge; bytes wait in the rx core during writes
    always_comb begin
        len_s      = {rx_data_s, len_lo_r};
        sync_hit_s = rx_valid_s && (rx_data_s == SYNC_BYTE);
        timeout_s  = (tmo_cnt_r == {TIMEOUT_BITS{1'b1}});
        err_s      = is_busy_state(state_r) && (frame_err_s || overrun_s || timeout_s);
        if ((state_r == ST_WR_SETUP) || (state_r == ST_WR_PULSE) ||
            (state_r == ST_WR_HOLD) || (state_r == ST_DONE)) begin
            rx_ack_s = 1'b0;
        end else begin
            rx_ack_s = rx_valid_s;
        end
    end

    // Loader next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (err_s) begin
            state_nxt_s = ST_ERR;
        end else begin
            case (state_r)
                ST_IDLE, ST_ERR: begin
                    if (sync_hit_s) state_nxt_s = ST_LEN_LO;
                    else            state_nxt_s = state_r;
                end
                ST_LEN_LO: begin
                    if (rx_valid_s) state_nxt_s = ST_LEN_HI;
                    else            state_nxt_s = state_r;
                end
                ST_LEN_HI: begin
                    if (!rx_valid_s)                     state_nxt_s = state_r;
                    else if (len_s > 16'(IMEM_BYTES))    state_nxt_s = ST_ERR;
                    else if (len_s == 16'h0000)          state_nxt_s = ST_CHECK;
                    else                                 state_nxt_s = ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (rx_valid_s) state_nxt_s = ST_WR_SETUP;
                    else            state_nxt_s = state_r;
                end
                ST_WR_SETUP: state_nxt_s = ST_WR_PULSE;
                ST_WR_PULSE: state_nxt_s = ST_WR_HOLD;
                ST_WR_HOLD: begin
                    if (remaining_r == REM_W'(1)) state_nxt_s = ST_CHECK;
                    else                          state_nxt_s = ST_WAIT_DATA;
                end
                ST_CHECK: begin
                    if (!rx_valid_s)                               state_nxt_s = state_r;
                    else if (sum8(sum_r, rx_data_s) == 8'h00)      state_nxt_s = ST_DONE;
                    else                                           state_nxt_s = ST_ERR;
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, registered outputs and datapath; outputs are derived from the next state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            len_lo_r    <= 8'h00;
            remaining_r <= {REM_W{1'b0}};
            sum_r       <= 8'h00;
            tmo_cnt_r   <= {TIMEOUT_BITS{1'b0}};
            hlt_r       <= 1'b0;
            pgm_addr_r  <= {ADDR_W{1'b0}};
            pgm_data_r  <= 8'h00;
            we_r        <= 1'b0;
            cpu_rst_r   <= 1'b0;
            busy_r      <= 1'b0;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= is_busy_state(state_nxt_s);
            we_r      <= (state_nxt_s == ST_WR_PULSE);
            cpu_rst_r <= (state_nxt_s == ST_DONE);
            if (rx_valid_s || !is_busy_state(state_r)) begin
                tmo_cnt_r <= {TIMEOUT_BITS{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TIMEOUT_BITS'(1);
            end

            if ((state_nxt_s == ST_LEN_LO) && (state_r != ST_LEN_LO)) begin
                hlt_r       <= 1'b1;
                load_done_r <= 1'b0;
                load_err_r  <= 1'b0;
                pgm_addr_r  <= {ADDR_W{1'b0}};
                sum_r       <= 8'h00;
            end else if (state_nxt_s == ST_DONE) begin
                hlt_r       <= 1'b0;
                load_done_r <= 1'b1;
            end else if ((state_nxt_s == ST_ERR) && (state_r != ST_ERR)) begin
                load_err_r  <= 1'b1;
            end

            if ((state_r == ST_LEN_LO) && rx_valid_s) begin
                len_lo_r <= rx_data_s;
            end
            if ((state_r == ST_LEN_HI) && rx_valid_s) begin
                remaining_r <= len_s[REM_W-1:0];
            end
            if ((state_r == ST_WAIT_DATA) && (state_nxt_s == ST_WR_SETUP)) begin
                pgm_data_r <= rx_data_s;
                sum_r      <= sum8(sum_r, rx_data_s);
            end
            // Address wraps naturally past the last IMEM byte; the wrapped value is never used
            if (state_r == ST_WR_HOLD) begin
                pgm_addr_r  <= pgm_addr_r + ADDR_W'(1);
                remaining_r <= remaining_r - REM_W'(1);
            end
        end
    end

    assign hlt         = hlt_r;
    assign pgm_mode    = hlt_r;
    assign pgm_addr    = pgm_addr_r;
    assign pgm_data    = pgm_data_r;
    assign inst_mem_we = we_r;
    assign cpu_rst     = cpu_rst_r;
    assign busy        = busy_r;
    assign load_done   = load_done_r;
    assign load_err    = load_err_r;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed self-checking bench for uart_program_loader with a fast 16-clocks-per-bit UART.
module tb_uart_program_loader;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       uart_rx;
    logic       hlt;
    logic       pgm_mode;
    logic [9:0] pgm_addr;
    logic [7:0] pgm_data;
    logic       inst_mem_we;
    logic       cpu_rst;
    logic       busy;
    logic       load_done;
    logic       load_err;

    always #5 sys_clk = ~sys_clk;

    uart_program_loader #(
        .CLK_FREQ    (16),
        .BAUD        (1),
        .IMEM_BYTES  (1024),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_BITS(10)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .uart_rx    (uart_rx),
        .hlt        (hlt),
        .pgm_mode   (pgm_mode),
        .pgm_addr   (pgm_addr),
        .pgm_data   (pgm_data),
        .inst_mem_we(inst_mem_we),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we_wide_cnt = 0;
    int cpu_rst_cnt = 0;
    int we_base;
    int rst_base;
    logic we_prev = 1'b0;
    logic [7:0] mem [0:1023];

    // IMEM model and pulse counters
    always @(posedge sys_clk) begin
        if (inst_mem_we) begin
            mem[pgm_addr] <= pgm_data;
            we_cnt <= we_cnt + 1;
        end
        if (inst_mem_we && we_prev) we_wide_cnt <= we_wide_cnt + 1;
        if (cpu_rst) cpu_rst_cnt <= cpu_rst_cnt + 1;
        we_prev <= inst_mem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {25'd0, hlt, pgm_mode, inst_mem_we, cpu_rst, busy, load_done, load_err}, 32'd0);
        check({tag, "_addr"}, {22'd0, pgm_addr}, 32'd0);
        check({tag, "_data"}, {24'd0, pgm_data}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge sys_clk);
        end
        uart_rx = 1'b1;
        repeat (20) @(negedge sys_clk);
    endtask

    task automatic send_frame3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(chk);
        repeat (20) @(negedge sys_clk);
    endtask

    initial begin
        sys_rst = 1'b1;
        uart_rx = 1'b1;
        repeat (4) @(negedge sys_clk);
        check_all_zero("reset");
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);

        // Good load: 11+22+33 = 66, 66+9A wraps to 0
        we_base = we_cnt;
        rst_base = cpu_rst_cnt;
        send_byte(8'hA5);
        check("sync_hlt_mode_busy", {29'd0, hlt, pgm_mode, busy}, 32'h7);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h9A);
        repeat (20) @(negedge sys_clk);
        check("good_mem0", {24'd0, mem[0]}, 32'h11);
        check("good_mem1", {24'd0, mem[1]}, 32'h22);
        check("good_mem2", {24'd0, mem[2]}, 32'h33);
        check("good_we_count", we_cnt - we_base, 32'd3);
        check("good_we_width", we_wide_cnt, 32'd0);
        check("good_cpu_rst", cpu_rst_cnt - rst_base, 32'd1);
        check("good_done_err", {30'd0, load_done, load_err}, 32'h2);
        check("good_hlt_mode_busy", {29'd0, hlt, pgm_mode, busy}, 32'h0);

        // Junk bytes and a short glitch in IDLE are ignored
        send_byte(8'h00);
        send_byte(8'h7F);
        check("junk_ignored", {29'd0, hlt, busy, load_done}, 32'h1);
        uart_rx = 1'b0;
        repeat (4) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge sys_clk);
        check("glitch_ignored", {29'd0, hlt, busy, load_err}, 32'h0);
        we_base = we_cnt;
        send_frame3(8'h44, 8'h55, 8'h66, 8'h01);
        check("junk_load_mem0", {24'd0, mem[0]}, 32'h44);
        check("junk_load_mem2", {24'd0, mem[2]}, 32'h66);
        check("junk_load_we", we_cnt - we_base, 32'd3);
        check("junk_load_done", {30'd0, load_done, load_err}, 32'h2);

        // Bad checksum: writes still happen, core stays halted
        we_base = we_cnt;
        rst_base = cpu_rst_cnt;
        send_frame3(8'h11, 8'h22, 8'h33, 8'h9B);
        check("badchk_we", we_cnt - we_base, 32'd3);
        check("badchk_mem1", {24'd0, mem[1]}, 32'h22);
        check("badchk_done_err", {30'd0, load_done, load_err}, 32'h1);
        check("badchk_hlt_mode_busy", {29'd0, hlt, pgm_mode, busy}, 32'h6);
        check("badchk_cpu_rst", cpu_rst_cnt - rst_base, 32'd0);

        // Oversized length (1025) from ERR, then an empty image
        we_base = we_cnt;
        rst_base = cpu_rst_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h04);
        repeat (20) @(negedge sys_clk);
        check("len1025_err", {30'd0, load_done, load_err}, 32'h1);
        check("len1025_hlt_busy", {30'd0, hlt, busy}, 32'h2);
        check("len1025_we", we_cnt - we_base, 32'd0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (20) @(negedge sys_clk);
        check("len0_done_err", {30'd0, load_done, load_err}, 32'h2);
        check("len0_hlt", {31'd0, hlt}, 32'h0);
        check("len0_we", we_cnt - we_base, 32'd0);
        check("len0_cpu_rst", cpu_rst_cnt - rst_base, 32'd1);

        // Inter-byte timeout after the first of two payload bytes
        we_base = we_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h55);
        check("tmo_busy_before", {30'd0, busy, load_err}, 32'h2);
        repeat (1100) @(negedge sys_clk);
        check("tmo_err", {30'd0, load_done, load_err}, 32'h1);
        check("tmo_hlt_busy", {30'd0, hlt, busy}, 32'h2);
        check("tmo_we", we_cnt - we_base, 32'd1);
        check("tmo_mem0", {24'd0, mem[0]}, 32'h55);
        send_byte(8'hA5);
        check("resync_err_hlt", {29'd0, load_err, hlt, busy}, 32'h3);

        // Reset in the middle of the second payload byte
        we_base = we_cnt;
        rst_base = cpu_rst_cnt;
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        uart_rx = 1'b0;
        repeat (40) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_all_zero("abort");
        sys_rst = 1'b0;
        uart_rx = 1'b1;
        repeat (200) @(negedge sys_clk);
        check("abort_we", we_cnt - we_base, 32'd1);
        check("abort_cpu_rst", cpu_rst_cnt - rst_base, 32'd0);
        check("abort_idle", {29'd0, hlt, busy, load_done}, 32'h0);
        we_base = we_cnt;
        send_frame3(8'h77, 8'h88, 8'h99, 8'h68);
        check("reload_mem0", {24'd0, mem[0]}, 32'h77);
        check("reload_mem1", {24'd0, mem[1]}, 32'h88);
        check("reload_mem2", {24'd0, mem[2]}, 32'h99);
        check("reload_we", we_cnt - we_base, 32'd3);
        check("reload_cpu_rst", cpu_rst_cnt - rst_base, 32'd1);
        check("reload_done", {29'd0, load_done, load_err, hlt}, 32'h4);
        check("final_we_width", we_wide_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
